// File: rtl/stopwatch_display_mux.sv
// Seven-segment scan driver for the stopwatch: frame-coherent digit snapshots,
// M.SS.t decimal points, dash for non-BCD codes, and blink/leading-zero blanking.
module stopwatch_display_mux #(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2,
  parameter int LZ_BLANK = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit_minute,
  input  logic [3:0] digit_sec_tens,
  input  logic [3:0] digit_sec_units,
  input  logic [3:0] digit_tenths,
  input  logic       running,
  input  logic       direction,
  output logic [3:0] anode,
  output logic [6:0] segments,
  output logic       dp,
  output logic [1:0] scan_idx
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Active-low segment pattern {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  logic [SCAN_W-1:0]  prescale_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_phase_r;
  logic [1:0]         scan_idx_r;
  logic [15:0]        snap_r;
  logic               live_r;
  logic [3:0]         anode_r;
  logic [6:0]         segments_r;
  logic               dp_r;

  logic               scan_tick_s;
  logic               blink_tick_s;
  logic [3:0]         digit_s;
  logic               snap_zero_s;
  logic               blink_en_s;
  logic               lz_hide_s;
  logic               hide_s;
  logic [3:0]         anode_s;
  logic [6:0]         seg_s;
  logic               dp_s;

  assign scan_tick_s  = (prescale_r == SCAN_LAST);
  assign blink_tick_s = (blink_cnt_r == BLINK_LAST);

  // Scan prescaler, digit index, blink timebase and frame snapshot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale_r    <= '0;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
      scan_idx_r    <= 2'd0;
      snap_r        <= 16'h0000;
      live_r        <= 1'b0;
    end else begin
      prescale_r  <= scan_tick_s ? '0 : prescale_r + 1'b1;
      blink_cnt_r <= blink_tick_s ? '0 : blink_cnt_r + 1'b1;
      if (blink_tick_s) blink_phase_r <= ~blink_phase_r;
      if (scan_tick_s) begin
        scan_idx_r <= scan_idx_r + 2'd1;
        live_r     <= 1'b1;
        // Latch at the end of the minute slot so the next frame is coherent.
        if (scan_idx_r == 2'd3)
          snap_r <= {digit_minute, digit_sec_tens, digit_sec_units, digit_tenths};
      end
    end
  end

  // Select and decode the current slot, then apply blink and leading-zero blanking.
  always_comb begin
    case (scan_idx_r)
      2'd0:    digit_s = snap_r[3:0];
      2'd1:    digit_s = snap_r[7:4];
      2'd2:    digit_s = snap_r[11:8];
      2'd3:    digit_s = snap_r[15:12];
      default: digit_s = 4'd0;
    endcase
    snap_zero_s = (snap_r == 16'h0000);
    blink_en_s  = (~running & ~snap_zero_s) | (~direction & snap_zero_s);
    lz_hide_s   = (LZ_BLANK != 0) && (scan_idx_r == 2'd3) && (snap_r[15:12] == 4'd0);
    hide_s      = lz_hide_s | (blink_en_s & ~blink_phase_r);
    anode_s     = hide_s ? 4'b1111 : ~(4'b0001 << scan_idx_r);
    seg_s       = seg_decode(digit_s);
    dp_s        = ~((scan_idx_r == 2'd1) | (scan_idx_r == 2'd3));
  end

  // Registered pin drivers; stay dark until the first digit slot after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode_r    <= 4'b1111;
      segments_r <= 7'h7F;
      dp_r       <= 1'b1;
    end else if (live_r) begin
      anode_r    <= anode_s;
      segments_r <= seg_s;
      dp_r       <= dp_s;
    end else begin
      anode_r    <= 4'b1111;
      segments_r <= 7'h7F;
      dp_r       <= 1'b1;
    end
  end

  assign anode    = anode_r;
  assign segments = segments_r;
  assign dp       = dp_r;
  assign scan_idx = scan_idx_r;

endmodule

// File: doc/stopwatch_display_mux.md
Name: stopwatch_display_mux

Overview:
Downstream consumer of the stopwatch core. Takes the four BCD digits plus the running/direction flags and drives a common-anode 4-digit seven-segment display by time-multiplexing one digit at a time. Adds frame-coherent digit snapshots, fixed decimal points (M.SS.t), invalid-code indication and a blink mode for paused or expired states. Sits between the stopwatch and the board pins.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
SCAN_HZ, 1000, digit-advance rate in Hz; SCAN_DIV = CLK_HZ/SCAN_HZ; must be >= 2
BLINK_HZ, 2, blink toggle period rate in Hz; BLINK_DIV = CLK_HZ/(2*BLINK_HZ)
LZ_BLANK, 0, 1 = blank the minute digit when it is 0

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserts immediately; releases synchronously to clock)
digit_minute  input  4  BCD minutes
digit_sec_tens  input  4  BCD seconds tens
digit_sec_units  input  4  BCD seconds units
digit_tenths  input  4  BCD tenths
running  input  1  stopwatch running flag
direction  input  1  1 = count up, 0 = count down
anode  output  4  active-low digit enables; anode[0] = tenths (rightmost), anode[3] = minute
segments  output  7  active-low segments; segments[0] = a ... segments[6] = g
dp  output  1  active-low decimal point
scan_idx  output  2  index of the digit currently driven (debug/verification)

Behaviour:
- Reset (reset = 0): anode = 4'b1111, segments = 7'h7F, dp = 1, scan_idx = 0, prescaler = 0, blink counter = 0, blink_phase = 1 (visible), snapshot = all zero.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. scan_tick is a one-cycle pulse at the terminal count.
- scan_idx: increments on scan_tick and wraps 3 -> 0. Digit map: 0 = tenths, 1 = sec_units, 2 = sec_tens, 3 = minute.
- Snapshot: all four input digits are latched together in the cycle where scan_tick is high and scan_idx = 3, so the next frame starts with coherent data. Inputs never feed the decode path directly, so a carry mid-frame cannot tear the display.
- Outputs are registered. anode, segments and dp reflect the new scan_idx one cycle after scan_tick, and stay stable for the whole digit slot.
- One-hot anode: anode = ~(4'b0001 << scan_idx), unless the digit is blanked, in which case anode = 4'b1111.
- Decode: BCD 0-9 maps to the standard 7-segment patterns (e.g. 0 -> 7'b1000000, 8 -> 7'b0000000). Codes 10-15 display a dash: only g lit (7'b0111111).
- Decimal point: dp = 0 when scan_idx is 1 or 3, otherwise dp = 1. Display format is M.SS.t.
- Leading-zero blank: if LZ_BLANK = 1, scan_idx = 3 and the snapshot minute = 0, then anode = 4'b1111.
- Blink counter: runs continuously, 0..BLINK_DIV-1, and toggles blink_phase at the terminal count.
- snap_zero: all four snapshot digits are 0.
- blink_en: (~running & ~snap_zero) | (~direction & snap_zero). Paused with a non-zero time blinks; a countdown that has expired blinks. Up mode cleared to zero shows a steady display.
- Blanking: when blink_en = 1 and blink_phase = 0, anode = 4'b1111. segments and dp still update, so the scan continues invisibly.
- running and direction are sampled every cycle and do not wait for a frame boundary.
- Reset mid-scan forces outputs dark immediately. The first visible digit appears one cycle after the first scan_tick following reset release.

Test Plan:
- Test parameters: CLK_HZ = 1000, SCAN_HZ = 100 (SCAN_DIV = 10), BLINK_HZ = 5 (BLINK_DIV = 100).
- Reset hold: apply reset = 0 for 5 cycles -> anode = 1111, segments = 7F, dp = 1, scan_idx = 0. Release -> first anode change lands exactly 11 cycles after release (10 cycles to scan_tick, plus 1 register cycle) at scan_idx = 1.
- Static scan: inputs 1,2,3,4 (min..tenths), running = 1, direction = 1 -> anode cycles 1110, 1101, 1011, 0111. Segments show 4, 3, 2, 1 in that order. dp = 0 only in slots 1 and 3.
- Tearing: change tenths 4 -> 5 while scan_idx = 1 -> the displayed tenths stays 4 until the next frame. Slot 0 of the following frame shows 5.
- Invalid code: digit_sec_tens = 4'hC -> slot 2 segments = 7'b0111111.
- Blink:
  - running = 0, digits 0,0,1,0 -> anode is all 1111 for 100 cycles, then scans for 100 cycles, repeating.
  - Digits all 0 with direction = 1 -> no blinking.
  - Digits all 0 with direction = 0 -> blinking.
- Leading-zero blank: LZ_BLANK = 1, minute = 0 -> slot 3 anode = 1111. Set minute = 1 -> slot 3 anode = 0111 starting with the next frame.
